// File: rtl/prefetch_queue_pkg.sv
// Shared widths, the reset-vector address and the prefetcher FSM encoding.
package prefetch_queue_pkg;

  localparam int unsigned BYTE   = 8;
  localparam int unsigned ADDR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_VEC_ADDR = 16'hFFFC;

  typedef enum logic [1:0] {
    VEC_LO   = 2'd0,
    VEC_HI   = 2'd1,
    VEC_WAIT = 2'd2,
    STREAM   = 2'd3
  } prefetch_state_t;

endpackage

// File: rtl/prefetch_queue_byte_fifo.sv
// byte_fifo: DEPTH-entry queue of {address, byte} pairs with push, pop, flush and count.
module prefetch_queue_byte_fifo
  import prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      push_i,
  input  logic [ADDR_W+BYTE-1:0]    wdata_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  output logic [ADDR_W+BYTE-1:0]    rdata_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  logic [ADDR_W+BYTE-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]        r_wr_ptr;
  logic [PtrW-1:0]        r_rd_ptr;
  logic [PtrW:0]          r_count;
  logic                   w_push;
  logic                   w_pop;

  assign w_pop  = pop_i && (r_count != '0);
  // Full-guard is belt and braces; the caller's credit rule already prevents overflow.
  assign w_push = push_i && (w_pop || (r_count != FullCnt));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata_i;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count <= r_count + (PtrW + 1)'(w_push) - (PtrW + 1)'(w_pop);
    end
  end

  assign rdata_o = r_mem[r_rd_ptr];
  assign count_o = r_count;

endmodule

// File: rtl/prefetch_queue.sv
// 6502 instruction-byte prefetcher: PC, in-flight tracking, credit-based issue and redirects.
// Build option PREFETCH_RESET_VECTOR_EN loads the start PC from $FFFC/$FFFD after reset.
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h8000
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [BYTE-1:0]   mem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [BYTE-1:0]   byte_o,
  output logic [ADDR_W-1:0] byte_pc_o,
  output logic              byte_valid_o,
  input  logic              byte_ready_i
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW:0] DepthCnt = (CntW + 1)'(DEPTH);

  logic [ADDR_W-1:0]      r_pc;
  logic [ADDR_W-1:0]      r_req_pc;
  logic                   r_inflight;
  logic                   r_run;
  logic                   w_stream;
  logic                   w_req;
  logic [ADDR_W-1:0]      w_addr;
  logic                   w_credit;
  logic [CntW-1:0]        w_count;
  logic [CntW:0]          w_occupancy;
  logic [ADDR_W+BYTE-1:0] w_head;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_flush;

`ifdef PREFETCH_RESET_VECTOR_EN
  prefetch_state_t r_state;
  logic [BYTE-1:0] r_vec_lo;
  assign w_stream = (r_state == STREAM);
`else
  assign w_stream = 1'b1;
`endif

  assign w_occupancy = {1'b0, w_count} + {{CntW{1'b0}}, r_inflight};
  assign w_credit    = (w_occupancy < DepthCnt);

  // r_run holds requests off until the first clock after reset so outputs read 0 in reset.
  always_comb begin
    w_req  = 1'b0;
    w_addr = '0;
    if (r_run) begin
      if (w_stream) begin
        w_req  = w_credit && !redirect_i;
        w_addr = r_pc;
      end
`ifdef PREFETCH_RESET_VECTOR_EN
      else if (r_state == VEC_LO) begin
        w_req  = 1'b1;
        w_addr = RESET_VEC_ADDR;
      end else if (r_state == VEC_HI) begin
        w_req  = 1'b1;
        w_addr = RESET_VEC_ADDR + 16'd1;
      end
`endif
    end
  end

  assign mem_req_o  = w_req;
  assign mem_addr_o = w_req ? w_addr : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_run      <= 1'b0;
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
`ifdef PREFETCH_RESET_VECTOR_EN
      r_state    <= VEC_LO;
      r_vec_lo   <= '0;
`endif
    end else begin
      r_run <= 1'b1;
      if (w_stream) begin
        if (redirect_i) begin
          r_pc       <= redirect_pc_i;
          r_inflight <= 1'b0;
        end else begin
          r_inflight <= w_req;
          if (w_req) begin
            r_pc     <= r_pc + 16'd1;
            r_req_pc <= r_pc;
          end
        end
      end
`ifdef PREFETCH_RESET_VECTOR_EN
      case (r_state)
        VEC_LO: begin
          if (r_run) r_state <= VEC_HI;
        end
        VEC_HI: begin
          r_vec_lo <= mem_rdata_i;
          r_state  <= VEC_WAIT;
        end
        VEC_WAIT: begin
          r_pc    <= {mem_rdata_i, r_vec_lo};
          r_state <= STREAM;
        end
        default: ;
      endcase
`endif
    end
  end

  assign w_flush = w_stream && redirect_i;
  assign w_push  = w_stream && r_inflight && !redirect_i;
  assign w_pop   = byte_valid_o && byte_ready_i && !redirect_i;

  prefetch_queue_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_byte_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (w_push),
    .wdata_i ({r_req_pc, mem_rdata_i}),
    .pop_i   (w_pop),
    .flush_i (w_flush),
    .rdata_o (w_head),
    .count_o (w_count)
  );

  assign byte_valid_o = (w_count != '0);
  assign byte_o       = byte_valid_o ? w_head[BYTE-1:0] : '0;
  assign byte_pc_o    = byte_valid_o ? w_head[ADDR_W+BYTE-1:BYTE] : '0;

endmodule
